// File: rtl/padder_param.sv
// Packs message words into RATE_WORDS-word blocks and applies Keccak-style multi-rate padding (PAD_BYTE ... 0x80).
// A completed block is held on out with buffer_full asserted until f_ack. While it is held, new input is ignored.
module padder_param #(
  parameter int         WORD_BYTES = 4,
  parameter int         RATE_WORDS = 18,
  parameter logic [7:0] PAD_BYTE   = 8'h01,
  localparam int        W          = 8 * WORD_BYTES,
  localparam int        BN         = $clog2(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [W-1:0]            in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [BN-1:0]           byte_num,
  input  logic                    f_ack,
  output logic                    buffer_full,
  output logic [W*RATE_WORDS-1:0] out,
  output logic                    out_ready,
  output logic                    out_last
);

  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] RATE_CNT = CW'(RATE_WORDS);

  typedef enum logic [1:0] {ABSORB, PAD_FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          accept;
  logic          shift;
  logic          ack;
  logic          pad_seen;
  logic [W-1:0]  padded;
  logic [W-1:0]  word_nxt;

  assign accept    = in_ready & ~buffer_full & (state == ABSORB);
  assign shift     = accept | (state == PAD_FILL);
  assign ack       = f_ack & buffer_full & (state == FULL);
  assign count_inc = count + 1'b1;
  assign out_ready = buffer_full;

  always_comb begin
    padded = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i < int'(byte_num))
        padded[W-1-8*i -: 8] = in[W-1-8*i -: 8];
      else if (i == int'(byte_num))
        padded[W-1-8*i -: 8] = PAD_BYTE;
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = '0;
    case (state)
      ABSORB: begin
        if (accept) begin
          word_nxt = is_last ? padded : in;
          if (count_inc == RATE_CNT) begin
            state_nxt = FULL;
            // A last word that closes the block also carries the final 0x80 bit.
            if (is_last)
              word_nxt[7] = 1'b1;
          end else if (is_last) begin
            state_nxt = PAD_FILL;
          end
        end
      end
      PAD_FILL: begin
        if (count_inc == RATE_CNT) begin
          state_nxt   = FULL;
          word_nxt[7] = 1'b1;
        end
      end
      FULL: begin
        if (ack)
          state_nxt = ABSORB;
      end
      default: state_nxt = ABSORB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ABSORB;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= '0;
      count       <= '0;
      buffer_full <= 1'b0;
      out_last    <= 1'b0;
      pad_seen    <= 1'b0;
    end else begin
      if (shift) begin
        out   <= {out[W*RATE_WORDS-W-1:0], word_nxt};
        count <= count_inc;
      end
      if (accept && is_last)
        pad_seen <= 1'b1;
      // buffer_full trails entry into FULL by one cycle; out is left to be overwritten.
      if (ack) begin
        count       <= '0;
        buffer_full <= 1'b0;
        out_last    <= 1'b0;
        pad_seen    <= 1'b0;
      end else begin
        buffer_full <= (state == FULL);
        out_last    <= (state == FULL) & pad_seen;
      end
    end
  end

endmodule

// File: doc/padder_param.md
PADDER_PARAM -- requirements
Module: padder_param

Interface
REQ-001 Parameter WORD_BYTES, default 4, bytes per input word; legal values 2, 4, 8.
REQ-002 Parameter RATE_WORDS, default 18, words per output block; legal values are 2 or more.
REQ-003 Parameter PAD_BYTE, default 8'h01, first padding byte (8'h01 = Keccak, 8'h06 = SHA-3).
REQ-004 Derived widths: W = 8*WORD_BYTES; BN = log2(WORD_BYTES).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in  input  W  message word; byte 0 is in[W-1:W-8].
REQ-008 in_ready  input  1  in is valid this cycle.
REQ-009 is_last  input  1  qualifies in_ready; this is the message's final, partial word.
REQ-010 byte_num  input  BN  number of valid leading bytes in the final word (0..WORD_BYTES-1).
REQ-011 f_ack  input  1  consumer has taken out; frees the buffer.
REQ-012 buffer_full  output  1  block complete, input stalled.
REQ-013 out  output  W*RATE_WORDS  block; first accepted word occupies the most significant word.
REQ-014 out_ready  output  1  equals buffer_full.
REQ-015 out_last  output  1  valid with buffer_full; the block ends a message.

Function
REQ-016 Accept condition: accept = in_ready & ~buffer_full & (state == ABSORB); in_ready at any other time is ignored (no stall flag, no data change).
REQ-017 On accept, out shifts left by W and the new word enters the least significant word, visible the next cycle; word count increments.
REQ-018 Non-last word: loaded unmodified.
REQ-019 Last word (is_last = 1): bytes 0..byte_num-1 come from in, byte byte_num = PAD_BYTE, remaining bytes = 0.
REQ-020 Next state after a last word: PAD_FILL, or FULL if it filled the block.
REQ-021 States: ABSORB, PAD_FILL, FULL.
REQ-022 ABSORB -> FULL when the RATE_WORDS-th word is written; buffer_full = 1 on the following cycle.
REQ-023 PAD_FILL: shifts in one all-zero word per cycle, with no input needed; PAD_FILL -> FULL when the count reaches RATE_WORDS.
REQ-024 Final block completion: when the block completed by a last word or by PAD_FILL is written, out[7] is ORed to 1 (last byte |= 0x80).
REQ-025 Same-byte padding: if the padded byte is the block's last byte, that byte becomes PAD_BYTE|0x80.
REQ-026 out_last = 1 iff the current full block contains the padding; 0 otherwise.
REQ-027 FULL: out, buffer_full and out_last are held until f_ack.
REQ-028 f_ack in FULL: next cycle buffer_full = 0, out_last = 0, count = 0, state = ABSORB; out is not cleared (it is overwritten by shifting).
REQ-029 f_ack outside FULL has no effect.
REQ-030 f_ack and in_ready in the same FULL cycle: the word is not accepted.
REQ-031 Multi-message: after a final block is acked, the next accepted word starts a new message; no reset is required.
REQ-032 Latency: last word with k words already buffered gives buffer_full exactly RATE_WORDS-k cycles after the accept edge.
REQ-033 Pure-padding message: byte_num = 0 with is_last yields word PAD_BYTE followed by zeros.
REQ-034 Full-length last word: a message whose length is a multiple of WORD_BYTES sends its last data word as non-last, then is_last with byte_num = 0.

Reset
REQ-035 reset = 1 forces, asynchronously: out = 0, buffer_full = 0, out_last = 0, count = 0, state = ABSORB.
REQ-036 Reset mid-operation: reset asserted in any state, including PAD_FILL and FULL, abandons the partial block; no padding is emitted afterwards.

Verification
Bench parameters: WORD_BYTES = 4, RATE_WORDS = 4, PAD_BYTE = 01.
REQ-037 Reset -> out = 0, buffer_full = 0, out_ready = 0, out_last = 0.
REQ-038 Four words 11111111, 22222222, 33333333, 44444444, non-last -> out = 11111111_22222222_33333333_44444444, buffer_full = 1, out_last = 0; then f_ack -> buffer_full = 0 next cycle.
REQ-039 AABBCCDD, is_last, byte_num = 2 -> out = AABB0100_00000000_00000000_00000080, buffer_full rises 4 cycles after accept, out_last = 1.
REQ-040 Three full words then 55667788, is_last, byte_num = 3 -> last word 55667781, out_last = 1.
REQ-041 Four non-last words, ack, then is_last with byte_num = 0 -> second block 01000000_00000000_00000000_00000080.
REQ-042 Stalls and abort:
- in_ready held during FULL, including the f_ack cycle -> no word accepted, out unchanged;
- reset during PAD_FILL -> all outputs 0 next cycle;
- a following message pads correctly.
